cordic_sequencer: RTL and testbench

CORDIC_SEQUENCER -- requirements
Module: cordic_sequencer

---
 rtl/cordic_sequencer.sv | 102 ++++++++++
 tb/tb_cordic_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sequencer.sv
// Control sequencer for an iterative CORDIC rotator: accepts an angle, drives the load/step/direction strobes, tracks residual z.
// Optional quadrant fold of |angle| > pi/2 is enabled by defining CORDIC_QUADRANT_FOLD_EN.
module cordic_sequencer #(
  parameter int unsigned N_ITER = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [17:0] in_angle,
  output logic [4:0]  lut_index,
  input  logic [17:0] lut_angle,
  output logic        dp_load,
  output logic        dp_step,
  output logic        dp_neg,
  output logic        dp_flip,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] residual
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  localparam logic [4:0] LAST_INDEX = 5'(N_ITER - 1);

  state_t      state;
  logic [17:0] z;
  logic [17:0] z_in;
  logic        flip_in;

`ifdef CORDIC_QUADRANT_FOLD_EN
  localparam logic signed [17:0] HALF_PI     = 18'sh10000;
  localparam logic signed [17:0] NEG_HALF_PI = -18'sh10000;

  // Adding pi (0x20000) maps the outer half-plane onto the inner one; datapath negates x,y to compensate.
  always_comb begin
    flip_in = ($signed(in_angle) > HALF_PI) || ($signed(in_angle) < NEG_HALF_PI);
    z_in    = flip_in ? in_angle + 18'h20000 : in_angle;
  end
`else
  always_comb begin
    flip_in = 1'b0;
    z_in    = in_angle;
  end
`endif

  // Direction follows the sign of z; only meaningful while a step strobe is up.
  assign dp_neg   = dp_step & z[17];
  assign residual = z;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      z         <= '0;
      lut_index <= '0;
      dp_flip   <= 1'b0;
      dp_load   <= 1'b0;
      dp_step   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            z        <= z_in;
            dp_flip  <= flip_in;
            in_ready <= 1'b0;
            dp_load  <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          dp_load   <= 1'b0;
          dp_step   <= 1'b1;
          lut_index <= '0;
          state     <= ITER;
        end
        ITER: begin
          if (z[17]) z <= z + lut_angle;
          else       z <= z - lut_angle;
          if (lut_index == LAST_INDEX) begin
            lut_index <= '0;
            dp_step   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            lut_index <= lut_index + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Self-checking bench for cordic_sequencer: vector table for load/fold behaviour, scoreboard for full jobs,
// and hand-written sequences for stall, mid-job reset and back-to-back acceptance.
module tb_cordic_sequencer;
  localparam int N = 16;
  localparam real PI = 3.14159265358979323846;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [17:0] in_angle = '0;
  logic        in_ready, dp_load, dp_step, dp_neg, dp_flip, out_valid;
  logic [4:0]  lut_index;
  logic [17:0] lut_angle, residual;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  cordic_sequencer #(.N_ITER(N)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_angle(in_angle), .lut_index(lut_index), .lut_angle(lut_angle),
    .dp_load(dp_load), .dp_step(dp_step), .dp_neg(dp_neg), .dp_flip(dp_flip),
    .out_valid(out_valid), .out_ready(out_ready), .residual(residual)
  );

  function automatic logic [17:0] atan_lut(input logic [4:0] i);
    real v;
    v = $atan(2.0 ** (-real'(i))) * 131072.0 / PI;
    return 18'(int'(v));
  endfunction

  assign lut_angle = atan_lut(lut_index);

  typedef struct {
    logic [17:0] z;
    logic        flip;
    logic [31:0] neg;
    int          acc;
  } exp_t;

  function automatic exp_t model(input logic [17:0] a);
    exp_t e;
    logic [17:0] zz;
    zz = a;
    e.flip = 1'b0;
`ifdef CORDIC_QUADRANT_FOLD_EN
    if ($signed(a) > 18'sd65536 || $signed(a) < -18'sd65536) begin
      zz = a + 18'h20000;
      e.flip = 1'b1;
    end
`endif
    e.neg = '0;
    for (int i = 0; i < N; i++) begin
      e.neg[i] = zz[17];
      zz = zz[17] ? zz + atan_lut(5'(i)) : zz - atan_lut(5'(i));
    end
    e.z = zz;
    e.acc = 0;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  exp_t        sbq[$];
  int          accs[$];
  int          cyc = 0;
  int          step_cnt = 0;
  logic [31:0] nmask = '0;
  logic        ov_seen = 1'b0;
  int          first_ov = 0;

  always @(negedge clock) begin
    exp_t e;
    cyc++;
    if (reset) begin
      sbq.delete();
      step_cnt = 0;
      ov_seen = 1'b0;
    end else begin
      if (dp_load) begin
        step_cnt = 0;
        nmask = '0;
      end
      if (dp_step) begin
        check("lut_index_seq", 32'(lut_index), 32'(step_cnt));
        if (step_cnt < 32) nmask[step_cnt] = dp_neg;
        step_cnt++;
      end
      if (out_valid && !ov_seen) begin
        ov_seen = 1'b1;
        first_ov = cyc;
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          $display("FAIL unexpected_out: out_valid with no job pending, residual %0h", residual);
        end else begin
          e = sbq.pop_front();
          check("residual", 32'(residual), 32'(e.z));
          check("out_flip", 32'(dp_flip), 32'(e.flip));
          check("neg_seq", nmask, e.neg);
          check("latency", 32'(first_ov - e.acc), 32'(N + 2));
          check("step_count", 32'(step_cnt), 32'(N));
        end
        ov_seen = 1'b0;
      end
      if (in_valid && in_ready) begin
        e = model(in_angle);
        e.acc = cyc;
        sbq.push_back(e);
        accs.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 100 && !in_ready; k++) tick();
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && !out_valid; k++) tick();
    if (!out_valid) check("done_timeout", 32'(out_valid), 32'd1);
    tick();
  endtask

  typedef struct {
    logic [17:0] angle;
    logic [17:0] z;
    logic        flip;
    logic        neg0;
  } vec_t;

  vec_t vt[8];

  task automatic run_vec(input vec_t v);
    wait_ready();
    in_valid = 1'b1;
    in_angle = v.angle;
    tick();
    in_valid = 1'b0;
    check("load_strobe", 32'(dp_load), 32'd1);
    check("load_z", 32'(residual), 32'(v.z));
    check("load_flip", 32'(dp_flip), 32'(v.flip));
    tick();
    check("step0_strobe", 32'(dp_step), 32'd1);
    check("step0_neg", 32'(dp_neg), 32'(v.neg0));
    wait_done();
  endtask

  initial begin
    logic [17:0] held;
    int n0;
    vt[0] = '{18'h08000, 18'h08000, 1'b0, 1'b0};
    vt[1] = '{18'h10000, 18'h10000, 1'b0, 1'b0};
    vt[2] = '{18'h30000, 18'h30000, 1'b0, 1'b1};
    vt[3] = '{18'h00000, 18'h00000, 1'b0, 1'b0};
    vt[4] = '{18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1};
`ifdef CORDIC_QUADRANT_FOLD_EN
    vt[5] = '{18'h18000, 18'h38000, 1'b1, 1'b1};
    vt[6] = '{18'h20000, 18'h00000, 1'b1, 1'b0};
    vt[7] = '{18'h1FFFF, 18'h3FFFF, 1'b1, 1'b1};
`else
    vt[5] = '{18'h18000, 18'h18000, 1'b0, 1'b0};
    vt[6] = '{18'h20000, 18'h20000, 1'b0, 1'b1};
    vt[7] = '{18'h1FFFF, 18'h1FFFF, 1'b0, 1'b0};
`endif

    // Reset state
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_residual", 32'(residual), 32'd0);
    check("rst_lut_index", 32'(lut_index), 32'd0);
    check("rst_strobes", {29'd0, dp_load, dp_step, dp_neg}, 32'd0);
    reset = 1'b0;
    tick();

    foreach (vt[i]) run_vec(vt[i]);

    // First-step arithmetic: z reaches zero after step 0 and stays non-negative
    wait_ready();
    in_valid = 1'b1;
    in_angle = 18'h08000;
    tick();
    in_valid = 1'b0;
    tick();
    check("s29_neg0", 32'(dp_neg), 32'd0);
    tick();
    check("s29_z1", 32'(residual), 32'd0);
    check("s29_neg1", 32'(dp_neg), 32'd0);
    check("s29_idx1", 32'(lut_index), 32'd1);
    wait_done();

    // Output stall in DONE
    wait_ready();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_angle = 18'h12345;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 60 && !out_valid; k++) tick();
    held = residual;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_residual", 32'(residual), 32'(held));
      check("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("stall_release_ready", 32'(in_ready), 32'd1);
    check("stall_release_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of the iterations
    wait_ready();
    in_valid = 1'b1;
    in_angle = 18'h1A000;
    tick();
    in_valid = 1'b0;
    tick();
    repeat (7) tick();
    check("mid_idx7", 32'(lut_index), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_in_ready", 32'(in_ready), 32'd1);
    check("mid_residual", 32'(residual), 32'd0);
    check("mid_lut_index", 32'(lut_index), 32'd0);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_strobes", {28'd0, dp_load, dp_step, dp_neg, dp_flip}, 32'd0);
    repeat (25) begin
      tick();
      if (out_valid) check("mid_no_out", 32'(out_valid), 32'd0);
    end
    run_vec(vt[2]);

    // Back-to-back jobs with in_valid held high
    wait_ready();
    n0 = accs.size();
    in_valid = 1'b1;
    in_angle = 18'h05000;
    for (int k = 0; k < 120 && accs.size() < n0 + 3; k++) tick();
    in_valid = 1'b0;
    check("b2b_count", 32'(accs.size() - n0), 32'd3);
    if (accs.size() >= n0 + 3) begin
      check("b2b_gap1", 32'(accs[n0 + 1] - accs[n0]), 32'(N + 3));
      check("b2b_gap2", 32'(accs[n0 + 2] - accs[n0 + 1]), 32'(N + 3));
    end
    wait_done();

    for (int k = 0; k < 100 && sbq.size() != 0; k++) tick();
    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
